// File: rtl/pattern_search_ctrl_if.sv
// Control and data-memory read-port bundle for pattern_search_ctrl.
// slave = the controller, master = top-level control plus memory.
interface pattern_search_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [3:0]        pat;
    logic              busy;
    logic              done;
    logic [7:0]        ctb;
    logic [7:0]        cts;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (
        output start, pat, mem_rdata,
        input  busy, done, ctb, cts, mem_rd, mem_addr
    );

    modport slave (
        input  start, pat, mem_rdata,
        output busy, done, ctb, cts, mem_rd, mem_addr
    );
endinterface

// File: rtl/pattern_search_ctrl.sv
// Memory-driven 4-bit pattern search: reads NBYTES bytes, counts in-byte (ctb) and whole-string (cts) matches.
// Optional `abort` input when PATTERN_SEARCH_ABORT_EN is defined.
module pattern_search_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int NBYTES    = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef PATTERN_SEARCH_ABORT_EN
    input  logic abort,
`endif
    pattern_search_ctrl_if.slave bus
);
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {IDLE, READ, COUNT, DONE} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_prev;
    logic [3:0]        r_pat;
    logic [7:0]        r_ctb;
    logic [7:0]        r_cts;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_inb;
    logic [1:0]        w_span;
    logic [5:0]        w_span_v;
    logic [IDX_W-1:0]  w_idx_nxt;

    assign w_span_v  = {r_prev[2:0], bus.mem_rdata[7:5]};
    assign w_idx_nxt = r_idx + 1'b1;

    always_comb begin
        w_inb  = '0;
        w_span = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bus.mem_rdata[i +: 4] == r_pat)
                w_inb = w_inb + 3'd1;
        end
        // Boundary windows only exist once a previous byte has been read.
        if (r_idx != '0) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (w_span_v[i +: 4] == r_pat)
                    w_span = w_span + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_prev  <= '0;
            r_pat   <= '0;
            r_ctb   <= '0;
            r_cts   <= '0;
            r_rd    <= 1'b0;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_pat   <= bus.pat;
                        r_ctb   <= '0;
                        r_cts   <= '0;
                        r_idx   <= '0;
                        r_prev  <= '0;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(BASE_ADDR);
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_rd    <= 1'b0;
                    r_state <= COUNT;
                end
                COUNT: begin
                    r_ctb  <= r_ctb + 8'(w_inb);
                    r_cts  <= r_cts + 8'(w_inb) + 8'(w_span);
                    r_prev <= bus.mem_rdata;
                    if (r_idx == IDX_W'(NBYTES - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(w_idx_nxt);
                        r_state <= READ;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
`ifdef PATTERN_SEARCH_ABORT_EN
            // Overrides the case above, including a COUNT-to-DONE step.
            if (abort && (r_state == READ || r_state == COUNT)) begin
                r_state <= IDLE;
                r_ctb   <= '0;
                r_cts   <= '0;
                r_rd    <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end
`endif
        end
    end

    assign bus.mem_rd   = r_rd;
    assign bus.mem_addr = r_addr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ctb      = r_ctb;
    assign bus.cts      = r_cts;
endmodule

// File: tb/tb_pattern_search_ctrl.sv
// Scoreboard bench for pattern_search_ctrl: expected counts come from a whole-bit-string reference model.
// Abort scenarios are exercised when PATTERN_SEARCH_ABORT_EN is defined.
module tb_pattern_search_ctrl;
    logic clk = 1'b0;
    logic reset;
`ifdef PATTERN_SEARCH_ABORT_EN
    logic abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] ctb;
        logic [7:0] cts;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [256];

    pattern_search_ctrl_if #(.ADDR_W(8)) bus ();

    pattern_search_ctrl #(
        .ADDR_W   (8),
        .BASE_ADDR(0),
        .NBYTES   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
`ifdef PATTERN_SEARCH_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Read data is valid the cycle after mem_rd; junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= 8'hA5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [63:0] s);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = s[63-8*i -: 8];
    endtask

    function automatic exp_t ref_counts(input logic [3:0] p);
        exp_t       e;
        logic [63:0] s;
        logic [7:0]  b;
        e.ctb = 0;
        e.cts = 0;
        for (int i = 0; i < 8; i++) s[63-8*i -: 8] = mem[i];
        for (int pos = 0; pos <= 60; pos++)
            if (s[pos +: 4] == p) e.cts++;
        for (int i = 0; i < 8; i++) begin
            b = mem[i];
            for (int j = 0; j <= 4; j++)
                if (b[j +: 4] == p) e.ctb++;
        end
        return e;
    endfunction

    task automatic do_search(input logic [3:0] p, input bit noise);
        exp_t e;
        int   cyc;
        int   reads;
        int   done_cyc;
        bit   got_done;
        sb.push_back(ref_counts(p));
        @(negedge clk);
        bus.start = 1'b1;
        bus.pat   = p;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; reads = 0; done_cyc = 0; got_done = 0;
        while (!got_done && cyc < 100) begin
            if (cyc == 1) begin
                check("cleared_ctb", 32'(bus.ctb), 0);
                check("cleared_cts", 32'(bus.cts), 0);
            end
            if (bus.mem_rd) begin
                check("rd_addr", 32'(bus.mem_addr), 32'(reads));
                reads++;
            end
            if (noise) begin
                bus.start = cyc[0];
                bus.pat   = cyc[1] ? ~p : p;
            end
            if (bus.done) begin
                got_done = 1;
                done_cyc = cyc;
                check("busy_in_done", 32'(bus.busy), 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (noise) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.pat   = p;
        check("done_seen", 32'(got_done), 1);
        check("done_cycle", 32'(done_cyc), 17);
        check("read_count", 32'(reads), 8);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctb", 32'(bus.ctb), 32'(e.ctb));
            check("cts", 32'(bus.cts), 32'(e.cts));
            @(negedge clk);
            check("done_width", 32'(bus.done), 0);
            check("busy_after", 32'(bus.busy), 0);
            @(negedge clk);
            check("idle_rd", 32'(bus.mem_rd), 0);
            check("hold_ctb", 32'(bus.ctb), 32'(e.ctb));
            check("hold_cts", 32'(bus.cts), 32'(e.cts));
        end
    endtask

`ifdef PATTERN_SEARCH_ABORT_EN
    task automatic abort_at(input int at_cyc);
        int cyc;
        bit seen_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.pat   = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < at_cyc) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_in_count", 32'(bus.busy & ~bus.mem_rd), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_rd", 32'(bus.mem_rd), 0);
        check("abort_ctb", 32'(bus.ctb), 0);
        check("abort_cts", 32'(bus.cts), 0);
        seen_done = bus.done;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check("abort_no_done", 32'(seen_done), 0);
    endtask
`endif

    initial begin
        bit seen_done;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.pat   = 4'h0;
`ifdef PATTERN_SEARCH_ABORT_EN
        abort     = 1'b0;
`endif
        load(64'h0);
        repeat (2) @(negedge clk);
        check("rst_rd",   32'(bus.mem_rd), 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_ctb",  32'(bus.ctb), 0);
        check("rst_cts",  32'(bus.cts), 0);
        reset = 1'b0;

        load(64'h0);
        do_search(4'hB, 0);
        load(64'h0000_0000_0000_B000);
        do_search(4'hB, 0);
        load(64'h0000_0000_00BB_B000);
        do_search(4'hB, 0);
        load(64'h0000_02C0_00BB_B000);
        do_search(4'hB, 0);
        load(64'h0);
        do_search(4'h0, 0);
        do_search(4'hF, 0);
        load(64'h0000_02C0_00BB_B000);
        do_search(4'hB, 1);

        // Reset in cycle 9 of a search with nonzero partial counts.
        @(negedge clk);
        bus.start = 1'b1;
        bus.pat   = 4'h0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_rd",   32'(bus.mem_rd), 0);
        check("mid_rst_addr", 32'(bus.mem_addr), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_ctb",  32'(bus.ctb), 0);
        check("mid_rst_cts",  32'(bus.cts), 0);
        seen_done = bus.done;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check("mid_rst_no_done", 32'(seen_done), 0);
        do_search(4'hB, 0);

`ifdef PATTERN_SEARCH_ABORT_EN
        load(64'h0000_02C0_00BB_B000);
        abort_at(8);
        abort_at(16);
        do_search(4'h0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
